// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multi-cycle RV32 control FSM: states, opcodes, mux/ALU encodings.
// The optional OP-IMM path is enabled by defining MC_CTRL_OPIMM_EN.
package mc_ctrl_pkg;

    localparam int unsigned ST_W_DEF = 4;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_ALU   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
`ifdef MC_CTRL_OPIMM_EN
        , S_EXEC_I = 4'd11
`endif
    } state_e;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_IMM    = 5'b00100;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_REG   = 2'b10
    } src_a_e;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'b00,
        SRCB_FOUR = 2'b01,
        SRCB_IMM  = 2'b10
    } src_b_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    mem_req;
        logic    mem_we;
        logic    i_or_d;
        logic    ir_write;
        logic    pc_en;
        logic    pc_src;
        logic    branch;
        src_a_e  alu_src_a;
        src_b_e  alu_src_b;
        alu_op_e alu_op;
        logic    mem_to_reg;
        logic    reg_write;
        logic    retire;
        logic    illegal;
    } ctrl_t;

    function automatic state_e decode_target(input logic [4:0] op);
        case (op)
            OP_R:              return S_EXEC_R;
            OP_LOAD, OP_STORE: return S_MEM_ADDR;
            OP_BRANCH:         return S_BRANCH;
`ifdef MC_CTRL_OPIMM_EN
            OP_IMM:            return S_EXEC_I;
`endif
            default:           return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Control-word decoder: current state plus handshake/zero inputs to datapath controls.
// Decodes S_EXEC_I only when MC_CTRL_OPIMM_EN is defined.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    input  logic   zero_i,
    output ctrl_t  ctrl_o
);

    logic pc_write;

    always_comb begin
        ctrl_o   = '0;
        pc_write = 1'b0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = mem_ready_i;
                pc_write         = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a = SRCA_OLDPC;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = SRCA_REG;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_WB_ALU: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.retire    = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = SRCA_REG;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.i_or_d  = 1'b1;
            end
            S_WB_MEM: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.retire     = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.mem_we  = 1'b1;
                ctrl_o.i_or_d  = 1'b1;
                ctrl_o.retire  = mem_ready_i;
            end
            S_BRANCH: begin
                ctrl_o.branch    = 1'b1;
                ctrl_o.alu_src_a = SRCA_REG;
                ctrl_o.alu_op    = ALU_SUB;
                ctrl_o.pc_src    = 1'b1;
                ctrl_o.retire    = 1'b1;
            end
            S_TRAP: ctrl_o.illegal = 1'b1;
`ifdef MC_CTRL_OPIMM_EN
            S_EXEC_I: begin
                ctrl_o.alu_src_a = SRCA_REG;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
`endif
            default: ;
        endcase
        // Conditional PC update only ever comes from the branch state.
        ctrl_o.pc_en = pc_write | (ctrl_o.branch & zero_i);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 control FSM: state register and next-state logic; outputs via mc_ctrl_outdec.
// Define MC_CTRL_OPIMM_EN to add the OP-IMM execute state.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ST_W = ST_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic            i_or_d,
    output logic            ir_write,
    output logic            pc_en,
    output logic            pc_src,
    output logic            branch,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            retire,
    output logic            illegal,
    output logic [ST_W-1:0] state_dbg
);

    state_e state_q;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET;
        end else begin
            case (state_q)
                S_RESET:    state_q <= S_FETCH;
                S_FETCH:    if (mem_ready) state_q <= S_DECODE;
                S_DECODE:   state_q <= decode_target(opcode);
                S_EXEC_R:   state_q <= S_WB_ALU;
                S_WB_ALU:   state_q <= S_FETCH;
                S_MEM_ADDR: state_q <= (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (mem_ready) state_q <= S_WB_MEM;
                S_WB_MEM:   state_q <= S_FETCH;
                S_MEM_WR:   if (mem_ready) state_q <= S_FETCH;
                S_BRANCH:   state_q <= S_FETCH;
                S_TRAP:     state_q <= S_TRAP;
`ifdef MC_CTRL_OPIMM_EN
                S_EXEC_I:   state_q <= S_WB_ALU;
`endif
                default:    state_q <= S_RESET;
            endcase
        end
    end

    mc_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .zero_i      (zero),
        .ctrl_o      (ctrl)
    );

    assign mem_req    = ctrl.mem_req;
    assign mem_we     = ctrl.mem_we;
    assign i_or_d     = ctrl.i_or_d;
    assign ir_write   = ctrl.ir_write;
    assign pc_en      = ctrl.pc_en;
    assign pc_src     = ctrl.pc_src;
    assign branch     = ctrl.branch;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign retire     = ctrl.retire;
    assign illegal    = ctrl.illegal;
    assign state_dbg  = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, corner sequences, random instructions.
// Honours MC_CTRL_OPIMM_EN to pick the expected OP-IMM behaviour.
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_en, pc_src, branch;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic       mem_to_reg, reg_write, retire, illegal;
    logic [3:0] state_dbg;
    logic [20:0] outs;

    int unsigned checks = 0;
    int unsigned errors = 0;

    multicycle_control #(.ST_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_en(pc_en), .pc_src(pc_src), .branch(branch), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .retire(retire), .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign outs = {mem_req, mem_we, i_or_d, ir_write, pc_en, pc_src, branch, alu_src_a,
                   alu_src_b, alu_op, mem_to_reg, reg_write, retire, illegal, state_dbg};

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Instruction seen as a list of phases: 0 = one plain cycle, 1 = fetch access,
    // 2 = data read, 3 = data write. A memory phase lasts until a cycle whose stall bit is clear.
    function automatic void model(input logic [4:0] op, input logic z, input logic [63:0] stall,
                                  output int unsigned lat, output int unsigned regw,
                                  output int unsigned pcen, output logic [63:0] req_v,
                                  output logic [63:0] iord_v, output logic [63:0] we_v);
        int unsigned ph[$];
        int unsigned k = 0;
        ph = '{1};
        regw = 0;
        pcen = 1;
        case (op)
            OP_R:      begin ph.push_back(0); ph.push_back(0); ph.push_back(0); regw = 1; end
            OP_LOAD:   begin ph.push_back(0); ph.push_back(0); ph.push_back(2); ph.push_back(0); regw = 1; end
            OP_STORE:  begin ph.push_back(0); ph.push_back(0); ph.push_back(3); end
            OP_BRANCH: begin ph.push_back(0); ph.push_back(0); pcen = 1 + int'(z); end
`ifdef MC_CTRL_OPIMM_EN
            OP_IMM:    begin ph.push_back(0); ph.push_back(0); ph.push_back(0); regw = 1; end
`endif
            default: ;
        endcase
        req_v = '0; iord_v = '0; we_v = '0;
        foreach (ph[i]) begin
            if (ph[i] == 0) begin
                k++;
            end else begin
                do begin
                    req_v[k]  = 1'b1;
                    iord_v[k] = (ph[i] != 1);
                    we_v[k]   = (ph[i] == 3);
                    k++;
                end while (k < 64 && stall[k-1]);
            end
        end
        lat = k;
    endfunction

    task automatic run_instr(input string name, input logic [4:0] op, input logic z,
                             input logic [63:0] stall, input int unsigned exp_lat,
                             input int unsigned exp_regw, input int unsigned exp_pcen,
                             input bit chk_trace, input logic [31:0] exp_trace);
        int unsigned m_lat, m_regw, m_pcen;
        logic [63:0] e_req, e_iord, e_we, g_req, g_iord, g_we, mask;
        logic [31:0] trace, tmask;
        int unsigned lat = 0, regw = 0, pcen = 0, k = 0;
        bit anyx = 0, done = 0;
        logic ld = 1'b0;
        logic [1:0] br = 2'b00;
        model(op, z, stall, m_lat, m_regw, m_pcen, e_req, e_iord, e_we);
        g_req = '0; g_iord = '0; g_we = '0; trace = '0;
        while (k < 64 && !done) begin
            @(posedge clk);
            #1;
            opcode = op; zero = z; mem_ready = ~stall[k];
            @(negedge clk);
            if ($isunknown(outs)) anyx = 1;
            g_req[k] = mem_req; g_iord[k] = i_or_d; g_we[k] = mem_we;
            if (k < 8) trace[4*k +: 4] = state_dbg;
            regw += int'(reg_write);
            pcen += int'(pc_en);
            if (retire === 1'b1) begin
                lat = k + 1; done = 1; ld = mem_to_reg; br = {pc_src, branch};
            end
            k++;
        end
        mask = (exp_lat >= 64) ? '1 : ((64'd1 << exp_lat) - 64'd1);
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_regw"}, 64'(regw), 64'(exp_regw));
        chk({name, "_pcen"}, 64'(pcen), 64'(exp_pcen));
        chk({name, "_memreq"}, g_req & mask, e_req & mask);
        chk({name, "_iord_we"}, {g_iord[31:0] & mask[31:0], g_we[31:0] & mask[31:0]},
            {e_iord[31:0] & mask[31:0], e_we[31:0] & mask[31:0]});
        chk({name, "_memtoreg"}, 64'(ld), 64'(op == OP_LOAD));
        chk({name, "_brsel"}, 64'(br), (op == OP_BRANCH) ? 64'd3 : 64'd0);
        chk({name, "_nox"}, 64'(anyx), 64'd0);
        if (chk_trace) begin
            tmask = (exp_lat >= 8) ? '1 : ((32'd1 << (4 * exp_lat)) - 32'd1);
            chk({name, "_trace"}, 64'(trace & tmask), 64'(exp_trace & tmask));
        end
    endtask

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic        z;
        logic [63:0] stall;
        int unsigned lat;
        int unsigned regw;
        int unsigned pcen;
        logic [31:0] trace;
    } vec_t;

    vec_t vecs[8];
    logic [4:0] ops[$];

    initial begin
        rst = 1'b1; mem_ready = 1'b1; opcode = OP_R; zero = 1'b0;
        #12;
        chk("reset_outs", 64'(outs), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        vecs[0] = '{"r_type", OP_R, 1'b0, 64'h0, 4, 1, 1,
                    {16'h0, S_WB_ALU, S_EXEC_R, S_DECODE, S_FETCH}};
        vecs[1] = '{"load", OP_LOAD, 1'b0, 64'h0, 5, 1, 1,
                    {12'h0, S_WB_MEM, S_MEM_RD, S_MEM_ADDR, S_DECODE, S_FETCH}};
        vecs[2] = '{"load_wait", OP_LOAD, 1'b0, 64'h38, 8, 1, 1,
                    {S_WB_MEM, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_MEM_ADDR, S_DECODE, S_FETCH}};
        vecs[3] = '{"store", OP_STORE, 1'b0, 64'h0, 4, 0, 1,
                    {16'h0, S_MEM_WR, S_MEM_ADDR, S_DECODE, S_FETCH}};
        vecs[4] = '{"store_wait", OP_STORE, 1'b1, 64'h8, 5, 0, 1,
                    {12'h0, S_MEM_WR, S_MEM_WR, S_MEM_ADDR, S_DECODE, S_FETCH}};
        vecs[5] = '{"branch_taken", OP_BRANCH, 1'b1, 64'h0, 3, 0, 2,
                    {20'h0, S_BRANCH, S_DECODE, S_FETCH}};
        vecs[6] = '{"branch_not", OP_BRANCH, 1'b0, 64'h0, 3, 0, 1,
                    {20'h0, S_BRANCH, S_DECODE, S_FETCH}};
        vecs[7] = '{"r_fetch_wait", OP_R, 1'b0, 64'h3, 6, 1, 1,
                    {8'h0, S_WB_ALU, S_EXEC_R, S_DECODE, S_FETCH, S_FETCH, S_FETCH}};

        for (int i = 0; i < 8; i++)
            run_instr(vecs[i].name, vecs[i].op, vecs[i].z, vecs[i].stall, vecs[i].lat,
                      vecs[i].regw, vecs[i].pcen, 1'b1, vecs[i].trace);

        ops = '{OP_R, OP_LOAD, OP_STORE, OP_BRANCH};
`ifdef MC_CTRL_OPIMM_EN
        ops.push_back(OP_IMM);
`endif
        for (int n = 0; n < 60; n++) begin
            logic [4:0]  op;
            logic        z;
            logic [63:0] stall;
            int unsigned lat, regw, pcen;
            logic [63:0] rq, io, we;
            op    = ops[$urandom_range(ops.size() - 1, 0)];
            z     = 1'($urandom);
            stall = {40'h0, 24'($urandom & $urandom)};
            model(op, z, stall, lat, regw, pcen, rq, io, we);
            run_instr($sformatf("rnd%0d", n), op, z, stall, lat, regw, pcen, 1'b0, 32'h0);
        end

        // Unsupported opcode parks in the trap state until reset.
        @(posedge clk); #1; opcode = 5'b11111; mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("trap_state", {illegal, state_dbg}, {1'b1, S_TRAP});
        begin
            int unsigned bad = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (illegal !== 1'b1 || mem_req !== 1'b0 || reg_write !== 1'b0 ||
                    retire !== 1'b0 || pc_en !== 1'b0) bad++;
            end
            chk("trap_hold", 64'(bad), 64'd0);
        end
        rst = 1'b1;
        #1;
        chk("trap_reset_clears", 64'(outs), 64'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef MC_CTRL_OPIMM_EN
        run_instr("opimm", OP_IMM, 1'b0, 64'h0, 4, 1, 1, 1'b1,
                  {16'h0, S_WB_ALU, S_EXEC_I, S_DECODE, S_FETCH});
`else
        @(posedge clk); #1; opcode = OP_IMM; mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("opimm_trap", {illegal, state_dbg}, {1'b1, S_TRAP});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif

        // Reset arriving mid-store must drop the request before the next clock edge.
        @(posedge clk); #1; opcode = OP_STORE; mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1; mem_ready = 1'b0;
        @(negedge clk);
        chk("midrst_pre", {mem_req, mem_we, i_or_d, state_dbg}, {3'b111, S_MEM_WR});
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_req", 64'(mem_req), 64'd0);
        chk("midrst_outs", 64'(outs), 64'd0);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_fetch", {mem_req, state_dbg}, {1'b1, S_FETCH});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
